// File: rtl/xyolo_write_ctrl.sv
// Write-stage sequencer: issues the vread stream, the xyolo load strobes and the vwrite stream.
// Issue tags ride shift registers so every strobe lines up with the read and xyolo latencies.
//
// state | meaning
// IDLE  | waiting for run; done holds the result of the last sequence
// ISSUE | one vread per cycle while in_avail is high
// DRAIN | reads finished; waiting for the last vwrite to leave the pipeline
module xyolo_write_ctrl #(
  parameter int MEM_ADDR_W    = 10,
  parameter int VWRITE_ADDR_W = 10,
  parameter int CNT_W         = 16,
  parameter int RD_LAT        = 2,
  parameter int XYOLO_LAT     = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic                     in_avail,
  input  logic [VWRITE_ADDR_W-1:0] cfg_n_out,
  input  logic [CNT_W-1:0]         cfg_n_mac,
  input  logic [MEM_ADDR_W-1:0]    cfg_rd_base,
  input  logic [MEM_ADDR_W-1:0]    cfg_out_stride,
  input  logic [VWRITE_ADDR_W-1:0] cfg_wr_base,
  input  logic                     cfg_maxpool,
  output logic                     vread_enB,
  output logic [MEM_ADDR_W-1:0]    vread_addrB,
  output logic                     ld_acc,
  output logic                     ld_mp,
  output logic                     ld_res,
  output logic                     vwrite_enB,
  output logic [VWRITE_ADDR_W-1:0] vwrite_addrB,
  output logic                     busy,
  output logic                     done
);

  localparam int K_W = VWRITE_ADDR_W + 2;
  localparam logic [XYOLO_LAT-1:0] WR_TOP = XYOLO_LAT'(1) << (XYOLO_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         n_mac_q, m_cnt;
  logic [K_W-1:0]           n_tot_q, k_cnt;
  logic [MEM_ADDR_W-1:0]    stride_q, row_addr, rd_addr;
  logic                     mp_q;
  logic [RD_LAT-1:0]        first_sr, last_sr, grp_sr;
  logic                     mp_grp_q;
  logic [XYOLO_LAT-1:0]     wr_sr;
  logic [VWRITE_ADDR_W-1:0] wr_addr;
  logic                     m_last, k_last, pending;

  assign m_last = (m_cnt == n_mac_q - CNT_W'(1));
  assign k_last = (k_cnt == n_tot_q - K_W'(1));
  // The write currently on vwrite_enB does not count: done must follow it by one cycle.
  assign pending = (|last_sr) | ld_mp | ld_res | mp_grp_q | (|(wr_sr & ~WR_TOP));

  assign vwrite_enB   = wr_sr[XYOLO_LAT-1];
  assign vwrite_addrB = wr_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      n_mac_q     <= '0;
      m_cnt       <= '0;
      n_tot_q     <= '0;
      k_cnt       <= '0;
      stride_q    <= '0;
      row_addr    <= '0;
      rd_addr     <= '0;
      mp_q        <= 1'b0;
      first_sr    <= '0;
      last_sr     <= '0;
      grp_sr      <= '0;
      mp_grp_q    <= 1'b0;
      wr_sr       <= '0;
      wr_addr     <= '0;
      vread_enB   <= 1'b0;
      vread_addrB <= '0;
      ld_acc      <= 1'b0;
      ld_mp       <= 1'b0;
      ld_res      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      vread_enB <= 1'b0;
      for (int i = RD_LAT - 1; i > 0; i--) begin
        first_sr[i] <= first_sr[i-1];
        last_sr[i]  <= last_sr[i-1];
        grp_sr[i]   <= grp_sr[i-1];
      end
      first_sr[0] <= 1'b0;
      last_sr[0]  <= 1'b0;
      grp_sr[0]   <= 1'b0;

      ld_acc   <= first_sr[RD_LAT-1];
      ld_mp    <= mp_q & last_sr[RD_LAT-1];
      mp_grp_q <= mp_q & last_sr[RD_LAT-1] & grp_sr[RD_LAT-1];
      ld_res   <= mp_q ? mp_grp_q : last_sr[RD_LAT-1];

      for (int j = XYOLO_LAT - 1; j > 0; j--) wr_sr[j] <= wr_sr[j-1];
      wr_sr[0] <= ld_res;
      if (vwrite_enB) wr_addr <= wr_addr + VWRITE_ADDR_W'(1);

      case (state)
        IDLE: begin
          if (run) begin
            done     <= 1'b0;
            busy     <= 1'b1;
            n_mac_q  <= cfg_n_mac;
            n_tot_q  <= cfg_maxpool ? {cfg_n_out, 2'b00} : {2'b00, cfg_n_out};
            stride_q <= cfg_out_stride;
            mp_q     <= cfg_maxpool;
            m_cnt    <= '0;
            k_cnt    <= '0;
            row_addr <= cfg_rd_base;
            rd_addr  <= cfg_rd_base;
            wr_addr  <= cfg_wr_base;
            state    <= (cfg_n_out == '0 || cfg_n_mac == '0) ? DRAIN : ISSUE;
          end
        end
        ISSUE: begin
          if (in_avail) begin
            vread_enB   <= 1'b1;
            vread_addrB <= rd_addr;
            first_sr[0] <= (m_cnt == '0);
            last_sr[0]  <= m_last;
            grp_sr[0]   <= mp_q & (k_cnt[1:0] == 2'b11);
            if (m_last) begin
              m_cnt    <= '0;
              k_cnt    <= k_cnt + K_W'(1);
              row_addr <= row_addr + stride_q;
              rd_addr  <= row_addr + stride_q;
              if (k_last) state <= DRAIN;
            end else begin
              m_cnt   <= m_cnt + CNT_W'(1);
              rd_addr <= rd_addr + MEM_ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (!pending) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xyolo_write_ctrl.sv
// Bench for xyolo_write_ctrl: table of configurations, a cycle-list reference model feeding
// per-strobe scoreboard queues, plus hand-written reset and abort sequences.
module tb_xyolo_write_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run, in_avail, cfg_maxpool;
  logic [9:0]  cfg_n_out, cfg_rd_base, cfg_out_stride, cfg_wr_base;
  logic [15:0] cfg_n_mac;
  logic        vread_enB, ld_acc, ld_mp, ld_res, vwrite_enB, busy, done;
  logic [9:0]  vread_addrB, vwrite_addrB;

  xyolo_write_ctrl dut (
    .clk(clk), .rst_n(rst_n), .run(run), .in_avail(in_avail),
    .cfg_n_out(cfg_n_out), .cfg_n_mac(cfg_n_mac), .cfg_rd_base(cfg_rd_base),
    .cfg_out_stride(cfg_out_stride), .cfg_wr_base(cfg_wr_base), .cfg_maxpool(cfg_maxpool),
    .vread_enB(vread_enB), .vread_addrB(vread_addrB), .ld_acc(ld_acc), .ld_mp(ld_mp),
    .ld_res(ld_res), .vwrite_enB(vwrite_enB), .vwrite_addrB(vwrite_addrB),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n_out; int n_mac; int rd_base; int stride; int wr_base; int mp;
    int stall_after; int stall_len; int busy_run_at;
    int exp_done; int exp_nrd; int exp_nwr;
  } vec_t;

  typedef struct { int cyc; int addr; } ev_t;

  vec_t vecs[9];
  ev_t  q_rd[$], q_acc[$], q_mp[$], q_res[$], q_wr[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   model_done;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit avail(input vec_t v, input int edge_n);
    return !(v.stall_len > 0 && edge_n >= v.stall_after + 1 &&
             edge_n < v.stall_after + 1 + v.stall_len);
  endfunction

  task automatic build_expected(input vec_t v);
    int n, total, rc, k, m;
    q_rd.delete(); q_acc.delete(); q_mp.delete(); q_res.delete(); q_wr.delete();
    n = v.mp ? 4 * v.n_out : v.n_out;
    total = (v.n_out == 0 || v.n_mac == 0) ? 0 : n * v.n_mac;
    for (int r = 0; r < total; r++) begin
      rc = r + 1 + ((v.stall_len > 0 && r >= v.stall_after) ? v.stall_len : 0);
      k = r / v.n_mac;
      m = r % v.n_mac;
      q_rd.push_back('{rc, (v.rd_base + k * v.stride + m) % 1024});
      if (m == 0) q_acc.push_back('{rc + 2, 0});
      if (m == v.n_mac - 1) begin
        if (v.mp == 0) q_res.push_back('{rc + 2, 0});
        else begin
          q_mp.push_back('{rc + 2, 0});
          if (k % 4 == 3) q_res.push_back('{rc + 3, 0});
        end
      end
    end
    foreach (q_res[j]) q_wr.push_back('{q_res[j].cyc + 3, (v.wr_base + j) % 1024});
    model_done = (q_wr.size() == 0) ? 1 : q_wr[q_wr.size()-1].cyc + 1;
  endtask

  task automatic pop_cmp(input string name, inout ev_t q[$], input int c,
                         input bit chk_addr, input int addr);
    ev_t e;
    if (q.size() == 0) begin
      check({name, "_unexpected_cycle"}, c, -1);
    end else begin
      e = q.pop_front();
      check({name, "_cycle"}, c, e.cyc);
      if (chk_addr) check({name, "_addr"}, addr, e.addr);
    end
  endtask

  task automatic run_case(input int id, input vec_t v);
    bit got_done = 1'b0;
    int n_rd = 0;
    int n_wr = 0;
    build_expected(v);
    @(negedge clk);
    cfg_n_out = 10'(v.n_out); cfg_n_mac = 16'(v.n_mac);
    cfg_rd_base = 10'(v.rd_base); cfg_out_stride = 10'(v.stride);
    cfg_wr_base = 10'(v.wr_base); cfg_maxpool = v.mp[0];
    run = 1'b1;
    in_avail = avail(v, 0);
    for (int c = 0; c < 200 && !got_done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("busy_after_run", busy, 1);
        check("done_cleared", done, 0);
      end
      if (vread_enB) begin n_rd++; pop_cmp("rd", q_rd, c, 1'b1, vread_addrB); end
      if (ld_acc) pop_cmp("ld_acc", q_acc, c, 1'b0, 0);
      if (ld_mp) pop_cmp("ld_mp", q_mp, c, 1'b0, 0);
      if (ld_res) pop_cmp("ld_res", q_res, c, 1'b0, 0);
      if (vwrite_enB) begin n_wr++; pop_cmp("wr", q_wr, c, 1'b1, vwrite_addrB); end
      if (done) begin
        got_done = 1'b1;
        check("done_cycle", c, v.exp_done);
        check("done_cycle_model", c, model_done);
        check("busy_at_done", busy, 0);
      end
      run = (c + 1 == v.busy_run_at);
      if (c == 0) begin
        cfg_n_out = 10'd7; cfg_n_mac = 16'd9; cfg_rd_base = 10'd333;
        cfg_out_stride = 10'd11; cfg_wr_base = 10'd99; cfg_maxpool = ~v.mp[0];
      end
      in_avail = avail(v, c + 1);
    end
    if (!got_done) check("done_timeout", 0, 1);
    check("nrd", n_rd, v.exp_nrd);
    check("nwr", n_wr, v.exp_nwr);
    check("leftover_events", q_rd.size() + q_acc.size() + q_mp.size() + q_res.size() + q_wr.size(), 0);
    @(negedge clk);
    check("done_holds", done, 1);
    if (n_errors > 0) $display("case %0d finished with %0d errors so far", id, n_errors);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          n_out n_mac base stride wr  mp st_a st_l brun done nrd nwr
    vecs[0] = '{2,    3,    10,  5,     4,  0, 0,   0,   -1,  12,  6,  2};
    vecs[1] = '{1,    2,    0,   2,     7,  1, 0,   0,   -1,  15,  8,  1};
    vecs[2] = '{2,    3,    10,  5,     4,  0, 2,   2,   -1,  14,  6,  2};
    vecs[3] = '{3,    1,    0,   4,     0,  0, 0,   0,   -1,  9,   3,  3};
    vecs[4] = '{2,    2,    1022,1,     1023,0,0,   0,   -1,  10,  4,  2};
    vecs[5] = '{0,    3,    10,  5,     4,  0, 0,   0,   -1,  1,   0,  0};
    vecs[6] = '{2,    0,    10,  5,     4,  0, 0,   0,   -1,  1,   0,  0};
    vecs[7] = '{2,    1,    100, 3,     20, 1, 3,   1,   -1,  16,  8,  2};
    vecs[8] = '{2,    3,    10,  5,     4,  0, 0,   0,   3,   12,  6,  2};

    rst_n = 1'b0; run = 1'b0; in_avail = 1'b0; cfg_maxpool = 1'b0;
    cfg_n_out = '0; cfg_n_mac = '0; cfg_rd_base = '0; cfg_out_stride = '0; cfg_wr_base = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({vread_enB, vread_addrB, ld_acc, ld_mp, ld_res,
                                 vwrite_enB, vwrite_addrB, busy, done}), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_case(i, vecs[i]);

    // Abort in the middle of ISSUE, then the basic case must replay exactly.
    @(negedge clk);
    cfg_n_out = 10'd2; cfg_n_mac = 16'd3; cfg_rd_base = 10'd10;
    cfg_out_stride = 10'd5; cfg_wr_base = 10'd4; cfg_maxpool = 1'b0;
    run = 1'b1; in_avail = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_pre_vread", vread_enB, 1);
    check("abort_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check("abort_outputs", int'({vread_enB, vread_addrB, ld_acc, ld_mp, ld_res,
                                    vwrite_enB, vwrite_addrB, busy, done}), 0);
    repeat (6) @(negedge clk);
    check("abort_no_writes", int'({vwrite_enB, vread_enB, busy}), 0);
    rst_n = 1'b1;
    run_case(9, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
